// File: rtl/iir_output_decimator.sv
// Post-filter decimator: drops settling samples, averages 2^LOG2_AVG accepted samples
// into one result and queues results in a small FIFO behind a valid/ready handshake.
module iir_output_decimator #(
    parameter int DATA_W         = 16,
    parameter int LOG2_AVG       = 6,
    parameter int SETTLE_SAMPLES = 256,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_valid,
    input  logic                     restart,
    output logic signed [DATA_W-1:0] avg_out,
    output logic                     avg_valid,
    input  logic                     avg_ready,
    output logic                     overflow,
    output logic                     settling
);

    localparam int ACC_W   = DATA_W + LOG2_AVG;
    localparam int CNT_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int SET_W   = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_SETTLE,
        ST_ACCUM
    } state_t;

    localparam state_t START_STATE = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;

    state_t                    state_q, state_d;
    logic [SET_W-1:0]          settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]          sample_cnt_q, sample_cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    logic signed [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic signed [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [FCNT_W-1:0]         count_q, count_d;

    logic                      overflow_q, overflow_d;
    logic signed [DATA_W-1:0]  avg_out_q, avg_out_d;
    logic                      avg_valid_q, avg_valid_d;
    logic                      settling_q, settling_d;

    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   sum_shift;
    logic signed [DATA_W-1:0]  result;
    logic                      result_push;
    logic                      pop;
    logic                      do_push;

    assign sum       = acc_q + ACC_W'(x_in);
    assign sum_shift = sum >>> LOG2_AVG;
    assign result    = sum_shift[DATA_W-1:0];

    // Settle/accumulate control; restart takes priority over a coincident sample.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        result_push  = 1'b0;
        if (restart) begin
            state_d      = START_STATE;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            acc_d        = '0;
        end else if (x_valid) begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = ST_ACCUM;
                        settle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_W'(1);
                    end
                end
                default: begin
                    if (sample_cnt_q == CNT_LAST) begin
                        result_push  = 1'b1;
                        sample_cnt_d = '0;
                        acc_d        = '0;
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                        acc_d        = sum;
                    end
                end
            endcase
        end
    end

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    always_comb begin
        pop        = avg_valid_q & avg_ready;
        do_push    = result_push & ((count_q != FIFO_FULL) | pop);
        overflow_d = overflow_q | (result_push & ~do_push);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
        avg_out_d   = mem_d[rd_ptr_d];
        avg_valid_d = (count_d != '0);
        settling_d  = (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= START_STATE;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            avg_out_q    <= '0;
            avg_valid_q  <= 1'b0;
            settling_q   <= (START_STATE == ST_SETTLE);
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            avg_out_q    <= avg_out_d;
            avg_valid_q  <= avg_valid_d;
            settling_q   <= settling_d;
        end
    end

    assign avg_out   = avg_out_q;
    assign avg_valid = avg_valid_q;
    assign overflow  = overflow_q;
    assign settling  = settling_q;

endmodule
